// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state
// encodings and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int SAC_WIDTH = 32;

  typedef enum logic [1:0] {
    SAC_IDLE   = 2'b00,
    SAC_SHIFT  = 2'b01,
    SAC_FINISH = 2'b10
  } sac_state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic element of the serial unit.
module serial_adder_ctrl_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Plain gate-level sum and carry.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit. One full adder is stepped over WIDTH
// cycles, LSB first; subtraction uses A + ~B + 1. Results are registered
// and only updated at the end of an operation.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             co_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH);
  // Count value of the MSB step and of the step just below it.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  sac_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             c_msb_in_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             co_q;
  logic             overflow_q;

  logic             fa_sum;
  logic             fa_co;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_d;

  serial_adder_ctrl_full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_sum),
    .co_o (fa_co)
  );

  // Next accumulator value (new sum bit enters at the top) and step count.
  always_comb begin
    acc_d = {fa_sum, acc_q[WIDTH-1:1]};
    cnt_d = cnt_q + 1'b1;
  end

  // Control FSM with datapath registers and registered host outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SAC_IDLE;
      cnt_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      co_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        SAC_IDLE: begin
          // BUSY follows acceptance so a held START keeps it high.
          busy_q <= start_i;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SAC_SHIFT;
          end
        end
        SAC_SHIFT: begin
          acc_q   <= acc_d;
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_d;
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == CNT_PREV) begin
            c_msb_in_q <= fa_co;
          end
          if (cnt_q == CNT_LAST) begin
            state_q <= SAC_FINISH;
          end
        end
        SAC_FINISH: begin
          done_q     <= 1'b1;
          result_q   <= acc_q;
          co_q       <= carry_q;
          overflow_q <= c_msb_in_q ^ carry_q;
          state_q    <= SAC_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= SAC_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign co_o       = co_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized bench for serial_adder_ctrl at WIDTH=32.
module tb_serial_adder_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, co, ovf;
  logic [W-1:0] result;

  int passed = 0;
  int total  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .sub_i      (sub),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .co_o       (co),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
    longint ua, ub, sa, sb, st;
    logic [W-1:0] r;
    logic mco, movf;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      r   = W'(ua - ub);
      mco = (ua >= ub);
      st  = sa - sb;
    end else begin
      r   = W'(ua + ub);
      mco = ((ua + ub) >= (64'd1 << W));
      st  = sa + sb;
    end
    movf = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return {movf, mco, r};
  endfunction

  // Present one START for exactly one accepting edge (edge 0).
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lsub);
    @(negedge clk);
    a = la; b = lb; sub = lsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] la, input logic [W-1:0] lb,
                        input logic lsub);
    int cyc;
    logic [W+1:0] exp;
    exp = model(la, lb, lsub);
    launch(la, lb, lsub);
    check({tag, ".busy_start"}, busy, 1);
    wait_done(cyc);
    check({tag, ".latency"}, cyc, 33);
    check({tag, ".result"}, result, exp[W-1:0]);
    check({tag, ".co"}, co, exp[W]);
    check({tag, ".ovf"}, ovf, exp[W+1]);
    $display("op %s a=%h b=%h sub=%0d -> result=%h co=%0d ovf=%0d lat=%0d",
             tag, la, lb, lsub, result, co, ovf, cyc);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".busy_end"}, busy, 0);
  endtask

  initial begin
    int cyc, ndone;
    int t_done [3];
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.co", co, 0);
    check("rst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op("add5p3", 32'd5, 32'd3, 1'b0);
    run_op("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("posovf", 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op("borrow", 32'd3, 32'd5, 1'b1);
    run_op("negovf", 32'h8000_0000, 32'd1, 1'b1);

    // START while busy is ignored.
    launch(32'd5, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("busystart.latency", cyc, 23);
    check("busystart.result", result, 8);
    @(posedge clk);
    #1;
    check("busystart.busy_fall", busy, 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("busystart.extra_done", ndone, 0);
    $display("op busystart result=%h extra_done=%0d", result, ndone);

    // Asynchronous reset in the middle of an operation.
    launch(32'd7, 32'd9, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.result", result, 0);
    check("midrst.co", co, 0);
    check("midrst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    $display("op midrst no_done=%0d", ndone);
    run_op("after_rst", 32'd2, 32'd2, 1'b0);

    // START held high across three operations.
    @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      while (done !== 1'b1 && cyc < 300) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      t_done[k] = cyc;
      check($sformatf("held.result%0d", k), result, 2);
      $display("op held%0d result=%h at_cycle=%0d", k, result, cyc);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("held.gap01", t_done[1] - t_done[0], 34);
    check("held.gap12", t_done[2] - t_done[1], 34);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("held.idle", busy, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 6 == 1) rb = 32'hFFFF_FFFF;
      if (i % 6 == 2) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
